fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 21 ++
 rtl/fetch_stage_pc_register.sv | 38 +++
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
package fetch_stage_pkg;

   // Fetch sequencer states; encoding is fixed so debug tooling can decode it.
   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_e;

   // Next-PC operation requested from the PC register.
   typedef enum logic [1:0] {
      PC_HOLD = 2'd0,
      PC_INC  = 2'd1,
      PC_LOAD = 2'd2
   } pc_op_e;

   localparam int unsigned MEM_DEPTH_DEF   = 36;
   localparam logic [7:0]  HALT_OPCODE_DEF = 8'hFF;

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program counter: hold, increment (wrapping at the last valid address) or load.
module fetch_stage_pc_register
   import fetch_stage_pkg::*;
#(
   parameter int unsigned PC_WIDTH  = 8,
   parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  pc_op_e              op,
   input  logic [PC_WIDTH-1:0] load_val,
   output logic [PC_WIDTH-1:0] pc
);

   localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(MEM_DEPTH - 1);

   logic [PC_WIDTH-1:0] pc_d;
   logic [PC_WIDTH-1:0] pc_q;

   // Next PC selection.
   always_comb begin
      pc_d = pc_q;
      case (op)
         PC_INC:  pc_d = (pc_q == LAST_PC) ? '0 : pc_q + PC_WIDTH'(1);
         PC_LOAD: pc_d = load_val;
         default: pc_d = pc_q;
      endcase
   end

   // PC flop with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) pc_q <= '0;
      else       pc_q <= pc_d;
   end

   assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: BOOT/RUN/HALT sequencer, PC control and IF/ID register.
// Optional macro FETCH_BOUND_CHECK_EN: out-of-range PC increment or jump target
// raises a sticky Fault and halts instead of wrapping/loading.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int unsigned                PC_WIDTH    = 8,
   parameter int unsigned                INSTR_WIDTH = 8,
   parameter int unsigned                MEM_DEPTH   = MEM_DEPTH_DEF,
   parameter logic [INSTR_WIDTH-1:0]     HALT_OPCODE = INSTR_WIDTH'(HALT_OPCODE_DEF)
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   Stall,
   input  logic                   Flush,
   input  logic                   JumpEn,
   input  logic [PC_WIDTH-1:0]    JumpTarget,
   input  logic [INSTR_WIDTH-1:0] InstrIn,
   output logic [PC_WIDTH-1:0]    PC,
   output logic [INSTR_WIDTH-1:0] IfIdInstr,
   output logic [PC_WIDTH-1:0]    IfIdPC,
   output logic                   IfIdValid,
   output logic                   Halted,
   output logic                   Fault
);

   fetch_state_e           state_d, state_q;
   logic [INSTR_WIDTH-1:0] instr_d, instr_q;
   logic [PC_WIDTH-1:0]    ifid_pc_d, ifid_pc_q;
   logic                   valid_d, valid_q;
   logic                   halted_d, halted_q;
   logic                   fault_d, fault_q;
   pc_op_e                 pc_op;
   logic                   jump_oob_c;
   logic                   inc_oob_c;

`ifdef FETCH_BOUND_CHECK_EN
   localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(MEM_DEPTH - 1);
   assign jump_oob_c = (32'(JumpTarget) >= 32'(MEM_DEPTH));
   assign inc_oob_c  = (PC == LAST_PC);
`else
   assign jump_oob_c = 1'b0;
   assign inc_oob_c  = 1'b0;
`endif

   fetch_stage_pc_register #(
      .PC_WIDTH  (PC_WIDTH),
      .MEM_DEPTH (MEM_DEPTH)
   ) u_pc_register (
      .clk      (Clk),
      .reset    (Reset),
      .op       (pc_op),
      .load_val (JumpTarget),
      .pc       (PC)
   );

   // Sequencer next state, IF/ID next contents and PC operation.
   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      ifid_pc_d = ifid_pc_q;
      valid_d   = valid_q;
      fault_d   = fault_q;
      pc_op     = PC_HOLD;
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            if (JumpEn) begin
               valid_d = 1'b0;
               if (jump_oob_c) begin
                  fault_d = 1'b1;
                  state_d = ST_HALT;
               end else begin
                  instr_d = '0;
                  pc_op   = PC_LOAD;
               end
            end else if (Flush) begin
               valid_d = 1'b0;
               instr_d = '0;
            end else if (!Stall) begin
               if (InstrIn == HALT_OPCODE) begin
                  instr_d   = InstrIn;
                  ifid_pc_d = PC;
                  valid_d   = 1'b1;
                  state_d   = ST_HALT;
               end else if (inc_oob_c) begin
                  valid_d = 1'b0;
                  fault_d = 1'b1;
                  state_d = ST_HALT;
               end else begin
                  instr_d   = InstrIn;
                  ifid_pc_d = PC;
                  valid_d   = 1'b1;
                  pc_op     = PC_INC;
               end
            end
         end
         ST_HALT: begin
            if (!Stall) valid_d = 1'b0;
         end
         default: state_d = ST_BOOT;
      endcase
      halted_d = (state_d == ST_HALT);
   end

   // State and IF/ID registers; reset overrides every other condition.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= ST_BOOT;
         instr_q   <= '0;
         ifid_pc_q <= '0;
         valid_q   <= 1'b0;
         halted_q  <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         ifid_pc_q <= ifid_pc_d;
         valid_q   <= valid_d;
         halted_q  <= halted_d;
         fault_q   <= fault_d;
      end
   end

   assign IfIdInstr = instr_q;
   assign IfIdPC    = ifid_pc_q;
   assign IfIdValid = valid_q;
   assign Halted    = halted_q;
   assign Fault     = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage against a rule-level reference model.
module tb_fetch_stage;

   localparam int DEPTH = 36;

   logic       Clk = 1'b0;
   logic       Reset, Stall, Flush, JumpEn;
   logic [7:0] JumpTarget, InstrIn;
   logic [7:0] PC, IfIdInstr, IfIdPC;
   logic       IfIdValid, Halted, Fault;

   logic [7:0] mem [256];

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int m_pc, m_instr, m_ifpc;
   bit m_valid, m_halted, m_boot;

   always #5 Clk = ~Clk;

   always_comb InstrIn = mem[PC];

   fetch_stage dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Stall      (Stall),
      .Flush      (Flush),
      .JumpEn     (JumpEn),
      .JumpTarget (JumpTarget),
      .InstrIn    (InstrIn),
      .PC         (PC),
      .IfIdInstr  (IfIdInstr),
      .IfIdPC     (IfIdPC),
      .IfIdValid  (IfIdValid),
      .Halted     (Halted),
      .Fault      (Fault)
   );

   // One clock: drive inputs, apply the behavioural rules at the edge, settle.
   task automatic tick(input bit rst, input bit st, input bit fl, input bit je, input logic [7:0] tgt);
      int fetched;
      Reset = rst; Stall = st; Flush = fl; JumpEn = je; JumpTarget = tgt;
      @(posedge Clk);
      if (rst) begin
         m_pc = 0; m_instr = 0; m_ifpc = 0; m_valid = 0; m_halted = 0; m_boot = 1;
      end else if (m_boot) begin
         m_boot = 0;
      end else if (m_halted) begin
         if (!st) m_valid = 0;
      end else if (je) begin
         m_pc = int'(tgt); m_valid = 0; m_instr = 0;
      end else if (fl) begin
         m_valid = 0; m_instr = 0;
      end else if (!st) begin
         fetched = int'(mem[m_pc]);
         m_instr = fetched; m_ifpc = m_pc; m_valid = 1;
         if (fetched == 255) m_halted = 1;
         else m_pc = (m_pc + 1) % DEPTH;
      end
      #1;
   endtask

   task automatic fill_random();
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 254));
   endtask

   task automatic test_reset();
      tick(1, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
      tick(1, 0, 0, 1, 8'd7);
      checks++; if (PC !== 8'd0) begin failures++; $display("FAIL reset_pc: got %0d expected 0", PC); end
      checks++; if (IfIdInstr !== 8'd0) begin failures++; $display("FAIL reset_instr: got %0h expected 0", IfIdInstr); end
      checks++; if (IfIdPC !== 8'd0) begin failures++; $display("FAIL reset_ifpc: got %0d expected 0", IfIdPC); end
      checks++; if ({IfIdValid, Halted, Fault} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b expected 000", {IfIdValid, Halted, Fault}); end
      // BOOT ignores jump/stall/flush and fetches nothing
      tick(0, 1, 1, 1, 8'd9);
      checks++; if (PC !== 8'd0 || IfIdValid !== 1'b0) begin failures++; $display("FAIL boot_idle: got pc=%0d valid=%b expected pc=0 valid=0", PC, IfIdValid); end
   endtask

   task automatic test_sequential();
      int exp_i [3];
      exp_i = '{8'h11, 8'h22, 8'h33};
      for (int k = 0; k < 3; k++) begin
         tick(0, 0, 0, 0, 8'd0);
         checks++;
         if (IfIdInstr !== 8'(exp_i[k]) || IfIdPC !== 8'(k) || IfIdValid !== 1'b1) begin
            failures++;
            $display("FAIL seq_fetch%0d: got instr=%0h pc=%0d valid=%b expected instr=%0h pc=%0d valid=1",
                     k, IfIdInstr, IfIdPC, IfIdValid, exp_i[k], k);
         end
      end
   endtask

   task automatic test_stall();
      // Re-establish PC=2 with IF/ID holding 22
      tick(1, 0, 0, 0, 8'd0); tick(0, 0, 0, 0, 8'd0);
      tick(0, 0, 0, 0, 8'd0); tick(0, 0, 0, 0, 8'd0);
      for (int k = 0; k < 3; k++) begin
         tick(0, 1, 0, 0, 8'd0);
         checks++;
         if (PC !== 8'd2 || IfIdInstr !== 8'h22 || IfIdValid !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold%0d: got pc=%0d instr=%0h valid=%b expected pc=2 instr=22 valid=1", k, PC, IfIdInstr, IfIdValid);
         end
      end
      tick(0, 0, 0, 0, 8'd0);
      checks++; if (IfIdInstr !== 8'h33 || IfIdPC !== 8'd2) begin failures++; $display("FAIL stall_resume: got instr=%0h pc=%0d expected 33/2", IfIdInstr, IfIdPC); end
   endtask

   task automatic test_jump_over_stall();
      tick(0, 1, 1, 1, 8'd20);
      checks++; if (PC !== 8'd20 || IfIdValid !== 1'b0 || IfIdInstr !== 8'd0) begin failures++; $display("FAIL jump_load: got pc=%0d valid=%b instr=%0h expected 20/0/0", PC, IfIdValid, IfIdInstr); end
      tick(0, 0, 0, 0, 8'd0);
      checks++; if (IfIdPC !== 8'd20 || IfIdValid !== 1'b1 || IfIdInstr !== mem[20] || PC !== 8'd21) begin failures++; $display("FAIL jump_fetch: got ifpc=%0d valid=%b pc=%0d expected 20/1/21", IfIdPC, IfIdValid, PC); end
   endtask

   task automatic test_flush();
      tick(0, 1, 1, 0, 8'd0);
      checks++; if (PC !== 8'd21 || IfIdValid !== 1'b0 || IfIdInstr !== 8'd0) begin failures++; $display("FAIL flush: got pc=%0d valid=%b instr=%0h expected 21/0/0", PC, IfIdValid, IfIdInstr); end
   endtask

   task automatic test_wrap();
      tick(0, 0, 0, 1, 8'd35);
      tick(0, 0, 0, 0, 8'd0);
`ifdef FETCH_BOUND_CHECK_EN
      checks++; if (PC !== 8'd35 || Fault !== 1'b1 || Halted !== 1'b1 || IfIdValid !== 1'b0) begin failures++; $display("FAIL wrap_fault: got pc=%0d fault=%b halted=%b expected 35/1/1", PC, Fault, Halted); end
`else
      checks++; if (PC !== 8'd0 || IfIdPC !== 8'd35 || Fault !== 1'b0 || Halted !== 1'b0) begin failures++; $display("FAIL wrap: got pc=%0d ifpc=%0d fault=%b expected 0/35/0", PC, IfIdPC, Fault); end
`endif
   endtask

   task automatic test_halt();
      fill_random();
      mem[5] = 8'hFF;
      tick(1, 0, 0, 0, 8'd0); tick(0, 0, 0, 0, 8'd0);
      for (int k = 0; k < 6; k++) tick(0, 0, 0, 0, 8'd0);
      checks++; if (IfIdInstr !== 8'hFF || IfIdValid !== 1'b1 || Halted !== 1'b1 || PC !== 8'd5) begin failures++; $display("FAIL halt_enter: got instr=%0h valid=%b halted=%b pc=%0d expected FF/1/1/5", IfIdInstr, IfIdValid, Halted, PC); end
      tick(0, 0, 0, 1, 8'd12);
      checks++; if (PC !== 8'd5 || IfIdValid !== 1'b0 || Halted !== 1'b1) begin failures++; $display("FAIL halt_ignore_jump: got pc=%0d valid=%b halted=%b expected 5/0/1", PC, IfIdValid, Halted); end
      tick(1, 0, 0, 0, 8'd0);
      checks++; if (PC !== 8'd0 || Halted !== 1'b0) begin failures++; $display("FAIL halt_reset: got pc=%0d halted=%b expected 0/0", PC, Halted); end
   endtask

   task automatic test_reset_mid_stall();
      tick(0, 0, 0, 0, 8'd0);
      tick(0, 0, 0, 0, 8'd0); tick(0, 0, 0, 0, 8'd0);
      tick(0, 1, 0, 0, 8'd0);
      tick(1, 1, 0, 1, 8'd30);
      checks++;
      if (PC !== 8'd0 || IfIdInstr !== 8'd0 || IfIdPC !== 8'd0 || IfIdValid !== 1'b0 || Halted !== 1'b0 || Fault !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_stall: got pc=%0d instr=%0h ifpc=%0d valid=%b halted=%b fault=%b expected all 0",
                  PC, IfIdInstr, IfIdPC, IfIdValid, Halted, Fault);
      end
   endtask

   task automatic test_random();
      bit st, fl, je;
      fill_random();
      tick(1, 0, 0, 0, 8'd0);
      for (int n = 0; n < 300; n++) begin
         st = ($urandom_range(0, 3) == 0);
         fl = ($urandom_range(0, 7) == 0);
         je = ($urandom_range(0, 9) == 0);
         tick(0, st, fl, je, 8'($urandom_range(0, DEPTH - 1)));
         checks++;
         if (PC !== 8'(m_pc) || IfIdInstr !== 8'(m_instr) || IfIdValid !== m_valid || Halted !== m_halted || Fault !== 1'b0 ||
             (m_valid && IfIdPC !== 8'(m_ifpc))) begin
            failures++;
            $display("FAIL random_cycle%0d: got pc=%0d instr=%0h ifpc=%0d valid=%b halted=%b expected pc=%0d instr=%0h ifpc=%0d valid=%b halted=%b",
                     n, PC, IfIdInstr, IfIdPC, IfIdValid, Halted, m_pc, m_instr, m_ifpc, m_valid, m_halted);
         end
      end
   endtask

   initial begin
      Reset = 1'b1; Stall = 1'b0; Flush = 1'b0; JumpEn = 1'b0; JumpTarget = 8'd0;
      fill_random();
      mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
      test_reset();
      test_sequential();
      test_stall();
      test_jump_over_stall();
      test_flush();
      test_wrap();
      test_halt();
      test_reset_mid_stall();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
